// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction prefetch queue in front of a byte-addressed
// instruction memory. Once started it fetches one little-endian word per
// cycle into a small FIFO and hands the head to a valid/ready consumer. A
// redirect flushes the queue and restarts fetching at the target.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst            - synchronous active-low reset
//   start          - begin fetching at start_address (honoured only in IDLE)
//   start_address  - first fetch byte address (low two bits ignored)
//   PCSrc          - redirect: flush queue, resume at PC_next_branch
//   PC_next_branch - redirect target byte address (low two bits ignored)
//   instruction    - word at queue head (0 when queue empty)
//   PC_out         - byte address of head word (0 when queue empty)
//   PC_next_normal - PC_out + 4 (0 when queue empty)
//   valid          - queue head holds an instruction
//   ready          - consumer accepts head; transfer on valid && ready
//   count          - current queue occupancy

// Byte-wide instruction store; contents are loaded from outside, never written here.
module fetch_queue_imem #(
  parameter int mem_bytes = 256
) (
  input  logic [$clog2(mem_bytes)-1:0] addr,
  output logic [31:0]                  word
);
  localparam int ab = $clog2(mem_bytes);

  logic [7:0] Data_Memory [0:mem_bytes-1];

  // Little-endian word assembly; byte offsets wrap inside the array.
  always_comb begin
    word = {Data_Memory[addr + ab'(2'd3)], Data_Memory[addr + ab'(2'd2)],
            Data_Memory[addr + ab'(2'd1)], Data_Memory[addr]};
  end
endmodule

module fetch_queue_unit #(
  parameter int                   word_size   = 32,
  parameter int                   mem_bytes   = 256,
  parameter int                   queue_depth = 4,
  parameter logic [word_size-1:0] reset_pc    = {word_size{1'b0}}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [word_size-1:0]           start_address,
  input  logic                           PCSrc,
  input  logic [word_size-1:0]           PC_next_branch,
  output logic [word_size-1:0]           instruction,
  output logic [word_size-1:0]           PC_out,
  output logic [word_size-1:0]           PC_next_normal,
  output logic                           valid,
  input  logic                           ready,
  output logic [$clog2(queue_depth):0]   count
);
  localparam int ab = $clog2(mem_bytes);
  localparam int pw = $clog2(queue_depth);
  localparam int cw = pw + 1;
  localparam logic [word_size-1:0] align_mask = {{(word_size-2){1'b1}}, 2'b00};
  localparam logic [word_size-1:0] pc_step    = word_size'(3'd4);
  localparam logic [pw-1:0]        ptr_one    = pw'(1'b1);
  localparam logic [cw-1:0]        cnt_full   = cw'(queue_depth);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [word_size-1:0] fetch_pc_r;
  logic [word_size-1:0] q_instr_r [0:queue_depth-1];
  logic [word_size-1:0] q_pc_r    [0:queue_depth-1];
  logic [pw-1:0]        rd_ptr_r;
  logic [pw-1:0]        wr_ptr_r;
  logic [cw-1:0]        count_r;
  logic [31:0]          mem_word_s;
  logic                 valid_s;
  logic                 transfer_s;
  logic                 enq_s;

  fetch_queue_imem #(.mem_bytes(mem_bytes)) instruction_memory (
    .addr (fetch_pc_r[ab-1:0]),
    .word (mem_word_s)
  );

  // Handshake and enqueue qualification. A full queue still accepts a new
  // word when the head leaves in the same cycle.
  always_comb begin
    valid_s    = (count_r != {cw{1'b0}});
    transfer_s = valid_s && ready;
    enq_s      = 1'b0;
    if (rst && (state_r == RUN) && !PCSrc) begin
      enq_s = (count_r != cnt_full) || transfer_s;
    end else begin
      enq_s = 1'b0;
    end
  end

  // Next-state logic: IDLE waits for start, RUN is left only through reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_next_s;
  end

  // Fetch PC, queue pointers and occupancy; reset beats redirect beats fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r <= reset_pc;
      rd_ptr_r   <= {pw{1'b0}};
      wr_ptr_r   <= {pw{1'b0}};
      count_r    <= {cw{1'b0}};
    end else if (state_r == IDLE) begin
      if (start) fetch_pc_r <= start_address & align_mask;
      else       fetch_pc_r <= fetch_pc_r;
    end else if (PCSrc) begin
      // A transfer in this cycle is simply absorbed by the flush.
      fetch_pc_r <= PC_next_branch & align_mask;
      rd_ptr_r   <= {pw{1'b0}};
      wr_ptr_r   <= {pw{1'b0}};
      count_r    <= {cw{1'b0}};
    end else begin
      if (enq_s) begin
        fetch_pc_r <= fetch_pc_r + pc_step;
        wr_ptr_r   <= wr_ptr_r + ptr_one;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (transfer_s) rd_ptr_r <= rd_ptr_r + ptr_one;
      else            rd_ptr_r <= rd_ptr_r;
      count_r <= count_r + cw'(enq_s) - cw'(transfer_s);
    end
  end

  // Queue storage; entries need no reset because occupancy gates their use.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      q_instr_r[wr_ptr_r] <= word_size'(mem_word_s);
      q_pc_r[wr_ptr_r]    <= fetch_pc_r;
    end
  end

  // Head presentation, forced to zero while the queue is empty.
  always_comb begin
    instruction    = {word_size{1'b0}};
    PC_out         = {word_size{1'b0}};
    PC_next_normal = {word_size{1'b0}};
    if (valid_s) begin
      instruction    = q_instr_r[rd_ptr_r];
      PC_out         = q_pc_r[rd_ptr_r];
      PC_next_normal = q_pc_r[rd_ptr_r] + pc_step;
    end else begin
      instruction    = {word_size{1'b0}};
      PC_out         = {word_size{1'b0}};
      PC_next_normal = {word_size{1'b0}};
    end
  end

  assign valid = valid_s;
  assign count = count_r;
endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  localparam int MB = 256;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        PCSrc = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] start_address = 32'd0;
  logic [31:0] PC_next_branch = 32'd0;
  logic [31:0] instruction, PC_out, PC_next_normal;
  logic        valid;
  logic [2:0]  count;

  int total = 0;
  int passed = 0;

  // Reference model state: plain queues of fetched (pc, word) pairs.
  logic [7:0]  mdl_mem [0:MB-1];
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] mq_pc [$];
  logic [31:0] mq_w  [$];

  always #5 clk = ~clk;

  fetch_queue_unit #(.word_size(32), .mem_bytes(MB), .queue_depth(QD), .reset_pc(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .start_address(start_address),
    .PCSrc(PCSrc), .PC_next_branch(PC_next_branch), .instruction(instruction),
    .PC_out(PC_out), .PC_next_normal(PC_next_normal), .valid(valid),
    .ready(ready), .count(count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]);
    return {mdl_mem[(b + 3) % MB], mdl_mem[(b + 2) % MB], mdl_mem[(b + 1) % MB], mdl_mem[b]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance the model by one clock using the current input values.
  task automatic model_update();
    if (!rst) begin
      m_run = 1'b0;
      m_pc  = 32'd0;
      mq_pc.delete();
      mq_w.delete();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1;
        m_pc  = start_address & 32'hFFFF_FFFC;
      end
    end else if (PCSrc) begin
      mq_pc.delete();
      mq_w.delete();
      m_pc = PC_next_branch & 32'hFFFF_FFFC;
    end else begin
      if (mq_pc.size() > 0 && ready) begin
        void'(mq_pc.pop_front());
        void'(mq_w.pop_front());
      end
      if (mq_pc.size() < QD) begin
        mq_pc.push_back(m_pc);
        mq_w.push_back(mem_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", {63'd0, valid}, {63'd0, (mq_pc.size() != 0)});
    chk("count", {61'd0, count}, 64'(mq_pc.size()));
    if (mq_pc.size() != 0) begin
      chk("instruction", {32'd0, instruction}, {32'd0, mq_w[0]});
      chk("pc_out", {32'd0, PC_out}, {32'd0, mq_pc[0]});
      chk("pc_next_normal", {32'd0, PC_next_normal}, {32'd0, mq_pc[0] + 32'd4});
    end else begin
      chk("instruction_idle", {32'd0, instruction}, 64'd0);
      chk("pc_out_idle", {32'd0, PC_out}, 64'd0);
      chk("pc_next_normal_idle", {32'd0, PC_next_normal}, 64'd0);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    rst = 1'b1; start = 1'b0; PCSrc = 1'b0; ready = 1'b0;
    start_address = 32'd0; PC_next_branch = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] init_bytes [0:11];
    init_bytes = '{8'h02, 8'h04, 8'h05, 8'h06, 8'h01, 8'h08,
                   8'h09, 8'h10, 8'h13, 8'h32, 8'h56, 8'h69};
    for (int i = 0; i < MB; i++) mdl_mem[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) mdl_mem[i] = init_bytes[i];
    mdl_mem[32] = 8'h11; mdl_mem[33] = 8'h22; mdl_mem[34] = 8'h33; mdl_mem[35] = 8'h44;
    for (int i = 0; i < MB; i++) dut.instruction_memory.Data_Memory[i] = mdl_mem[i];
    m_run = 1'b0; m_pc = 32'd0;

    // Reset state.
    rst = 1'b0;
    step();
    step();
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_count", {61'd0, count}, 64'd0);

    // Sequential fetch with ready held high.
    rst = 1'b1; start = 1'b1; start_address = 32'd0; ready = 1'b1;
    step();
    start = 1'b0;
    chk("start_no_enqueue_yet", {63'd0, valid}, 64'd0);
    step();
    chk("seq0_instr", {32'd0, instruction}, 64'h0605_0402);
    chk("seq0_pc", {32'd0, PC_out}, 64'd0);
    step();
    chk("seq1_instr", {32'd0, instruction}, 64'h1009_0801);
    chk("seq1_pc", {32'd0, PC_out}, 64'd4);
    step();
    chk("seq2_instr", {32'd0, instruction}, 64'h6956_3213);
    chk("seq2_pc", {32'd0, PC_out}, 64'd8);

    // Redirect flush and refetch from the aligned target.
    PCSrc = 1'b1; PC_next_branch = 32'h422;
    step();
    PCSrc = 1'b0;
    chk("flush_valid", {63'd0, valid}, 64'd0);
    chk("flush_count", {61'd0, count}, 64'd0);
    step();
    chk("branch_pc", {32'd0, PC_out}, 64'h420);
    chk("branch_instr", {32'd0, instruction}, 64'h4433_2211);
    chk("branch_next", {32'd0, PC_next_normal}, 64'h424);

    // Backpressure: queue fills to depth and holds its head.
    do_reset();
    start = 1'b1; start_address = 32'd0; ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("full_count", {61'd0, count}, 64'd4);
    chk("full_head_instr", {32'd0, instruction}, 64'h0605_0402);
    chk("full_head_pc", {32'd0, PC_out}, 64'd0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("refill_count", {61'd0, count}, 64'd4);
      chk("refill_pc", {32'd0, PC_out}, 64'(32'd4 * (i + 1)));
    end

    // Memory wrap at the top of the byte array.
    do_reset();
    start = 1'b1; start_address = 32'd252; ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("wrap_pc0", {32'd0, PC_out}, 64'd252);
    step();
    chk("wrap_pc1", {32'd0, PC_out}, 64'd256);
    chk("wrap_instr1", {32'd0, instruction}, 64'h0605_0402);

    // PC wrap at 2^32 with an unaligned start address.
    do_reset();
    start = 1'b1; start_address = 32'hFFFF_FFFE; ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pcwrap_pc0", {32'd0, PC_out}, 64'hFFFF_FFFC);
    chk("pcwrap_next0", {32'd0, PC_next_normal}, 64'd0);
    step();
    chk("pcwrap_pc1", {32'd0, PC_out}, 64'd0);

    // Reset mid-run, then redirect ignored while idle.
    do_reset();
    start = 1'b1; start_address = 32'd0; ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_reset_count", {61'd0, count}, 64'd3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrun_reset_count", {61'd0, count}, 64'd0);
    PCSrc = 1'b1; PC_next_branch = 32'h40;
    step();
    PCSrc = 1'b0;
    step();
    chk("idle_pcsrc_valid", {63'd0, valid}, 64'd0);
    start = 1'b1; start_address = 32'h10;
    step();
    start = 1'b0;
    step();
    chk("restart_pc", {32'd0, PC_out}, 64'h10);

    // Reset wins over simultaneous start and redirect.
    ready = 1'b1;
    rst = 1'b0; PCSrc = 1'b1; start = 1'b1; start_address = 32'h80; PC_next_branch = 32'h90;
    step();
    clear_inputs();
    chk("prio_count", {61'd0, count}, 64'd0);
    step();
    step();
    chk("prio_stays_idle", {63'd0, valid}, 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 63) != 0);
      start          = ($urandom_range(0, 5) == 0);
      start_address  = $urandom;
      PCSrc          = ($urandom_range(0, 11) == 0);
      PC_next_branch = $urandom;
      ready          = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
